mix_layer_tm: RTL and testbench

Time-multiplexed, parametrised mixing layer for the hidden-state datapath. Computes Y = W·X' on an N×N signed fixed-point matrix, with X' = X or Xᵀ selected per run. The result is produced by LANES shared MAC lanes instead of one engine per row.
Weights are streamed from an external synchronous ROM/RAM. The block drops into the mixer pipeline where the fixed 24-engine layer sits today, trading latency for area.

---
 rtl/mix_layer_tm_pkg.sv | 21 ++
 rtl/mix_layer_tm_mac_lane.sv | 43 ++++
 rtl/mix_layer_tm.sv | 176 +++++++++++++++++
 tb/tb_mix_layer_tm.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_layer_tm_pkg.sv
// Shared defaults, FSM encoding and width helper for the time-multiplexed mixing layer.
package mix_layer_tm_pkg;

    localparam int unsigned MIX_BIT_LENGTH = 16;
    localparam int unsigned MIX_HID_LENGTH = 24;
    localparam int unsigned MIX_FRAC       = 8;
    localparam int unsigned MIX_LANES      = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // $clog2 clamped to at least one bit so degenerate counters stay legal
    function automatic int unsigned clog2_1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mix_layer_tm_mac_lane.sv
// One signed MAC lane: accumulate, restart on first term, shift down by FRAC and saturate.
module mac_lane
    import mix_layer_tm_pkg::*;
#(
    parameter int unsigned BW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACC_W = 37
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 first,
    input  logic signed [BW-1:0] w,
    input  logic signed [BW-1:0] x,
    output logic [BW-1:0]        res_c
);

    logic signed [2*BW-1:0]  prod_c;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt_c;
    logic signed [ACC_W-1:0] shr_c;

    assign prod_c    = w * x;
    assign acc_nxt_c = first ? ACC_W'(prod_c) : acc + ACC_W'(prod_c);
    assign shr_c     = acc_nxt_c >>> FRAC;

    // Saturate when the bits above the result's sign bit are not a pure sign extension
    always_comb begin
        res_c = shr_c[BW-1:0];
        if (!((&shr_c[ACC_W-1:BW-1]) || (~|shr_c[ACC_W-1:BW-1]))) begin
            res_c = shr_c[ACC_W-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt_c;
        end
    end

endmodule

// File: rtl/mix_layer_tm.sv
// Time-multiplexed mixing layer: Y = W * X' with LANES shared MAC lanes and a streamed weight ROM.
module mix_layer_tm
    import mix_layer_tm_pkg::*;
#(
    parameter int unsigned N          = MIX_HID_LENGTH,
    parameter int unsigned BIT_LENGTH = MIX_BIT_LENGTH,
    parameter int unsigned FRAC       = MIX_FRAC,
    parameter int unsigned LANES      = MIX_LANES,
    parameter int unsigned ACC_W      = 2*BIT_LENGTH + $clog2(N)
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 run,
    input  logic                                 transpose,
    input  logic [N*N*BIT_LENGTH-1:0]            data_in,
    output logic [clog2_1((N/LANES)*N)-1:0]      weight_addr,
    output logic                                 weight_en,
    input  logic [LANES*BIT_LENGTH-1:0]          weight_data,
    output logic                                 busy,
    output logic                                 valid,
    output logic [N*N*BIT_LENGTH-1:0]            data_out
);

    localparam int unsigned G  = N / LANES;
    localparam int unsigned GW = clog2_1(G);
    localparam int unsigned CW = clog2_1(N);
    localparam int unsigned AW = clog2_1(G*N);
    localparam int unsigned BW = BIT_LENGTH;
    localparam int unsigned MW = N*N*BW;

    if (N % LANES != 0) begin : g_lane_chk
        $error("mix_layer_tm: N must be a multiple of LANES");
    end

    state_t          state, state_nxt;
    logic [GW-1:0]   g, g_nxt, iss_g, s1_g;
    logic [CW-1:0]   c, c_nxt, iss_c, s1_c;
    logic [CW-1:0]   k, k_nxt, iss_k, s1_k;
    logic            en_nxt, last_iss, last_nxt, load_c, s1_v;
    logic [AW-1:0]   addr_nxt;
    logic [MW-1:0]   op_x, op_cap_c;
    logic [BW-1:0]   x_sel_c;
    logic            first_c;
    logic [BW-1:0]   lane_res_c [LANES];

    // Operand capture: X' = X or its transpose
    always_comb begin
        op_cap_c = '0;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned cc = 0; cc < N; cc++) begin
                op_cap_c[(N*r+cc)*BW +: BW] = transpose ? data_in[(N*cc+r)*BW +: BW]
                                                        : data_in[(N*r+cc)*BW +: BW];
            end
        end
    end

    // Next state and issue counters; loop order g outer, c middle, k inner
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        c_nxt     = c;
        k_nxt     = k;
        en_nxt    = 1'b0;
        addr_nxt  = weight_addr;
        last_nxt  = 1'b0;
        load_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    load_c    = 1'b1;
                    state_nxt = S_CALC;
                    g_nxt     = '0;
                    c_nxt     = '0;
                    k_nxt     = '0;
                end
            end
            S_CALC: begin
                if (last_iss) begin
                    state_nxt = S_DRAIN;
                end else begin
                    en_nxt   = 1'b1;
                    addr_nxt = AW'(32'(g)*N + 32'(k));
                    last_nxt = (g == GW'(G-1)) && (c == CW'(N-1)) && (k == CW'(N-1));
                    if (k != CW'(N-1)) begin
                        k_nxt = k + CW'(1);
                    end else begin
                        k_nxt = '0;
                        if (c != CW'(N-1)) begin
                            c_nxt = c + CW'(1);
                        end else begin
                            c_nxt = '0;
                            g_nxt = g + GW'(1);
                        end
                    end
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            g           <= '0;
            c           <= '0;
            k           <= '0;
            weight_en   <= 1'b0;
            weight_addr <= '0;
            last_iss    <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            iss_g       <= '0;
            iss_c       <= '0;
            iss_k       <= '0;
            s1_v        <= 1'b0;
            s1_g        <= '0;
            s1_c        <= '0;
            s1_k        <= '0;
            op_x        <= '0;
        end else begin
            state       <= state_nxt;
            g           <= g_nxt;
            c           <= c_nxt;
            k           <= k_nxt;
            weight_en   <= en_nxt;
            weight_addr <= addr_nxt;
            last_iss    <= last_nxt;
            busy        <= (state_nxt != S_IDLE);
            valid       <= (state_nxt == S_DONE);
            iss_g       <= g;
            iss_c       <= c;
            iss_k       <= k;
            // Tags line up with weight_data, which arrives one cycle after weight_en
            s1_v        <= weight_en;
            s1_g        <= iss_g;
            s1_c        <= iss_c;
            s1_k        <= iss_k;
            if (load_c) begin
                op_x <= op_cap_c;
            end
        end
    end

    assign x_sel_c = op_x[(N*32'(s1_k) + 32'(s1_c))*BW +: BW];
    assign first_c = (s1_k == '0);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .BW    (BW),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk   (clk),
            .rst   (rst),
            .en    (s1_v),
            .first (first_c),
            .w     (weight_data[l*BW +: BW]),
            .x     (x_sel_c),
            .res_c (lane_res_c[l])
        );
    end

    // Final term of a dot product: write Y[g*LANES+l][c] in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (s1_v && (s1_k == CW'(N-1))) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                data_out[(N*(32'(s1_g)*LANES + l) + 32'(s1_c))*BW +: BW] <= lane_res_c[l];
            end
        end
    end

endmodule

// File: tb/tb_mix_layer_tm.sv
// Scoreboard bench for mix_layer_tm: integer reference model, 1-cycle weight ROM, decoupled monitor.
module tb_mix_layer_tm;

    localparam int unsigned N     = 4;
    localparam int unsigned LANES = 2;
    localparam int unsigned BW    = 16;
    localparam int unsigned FRAC  = 8;
    localparam int unsigned G     = N / LANES;
    localparam int unsigned T     = N*N*N / LANES;
    localparam int unsigned MW    = N*N*BW;
    localparam int unsigned AW    = 3;

    logic                  clk;
    logic                  rst;
    logic                  run;
    logic                  transpose;
    logic [MW-1:0]         data_in;
    logic [AW-1:0]         weight_addr;
    logic                  weight_en;
    logic [LANES*BW-1:0]   weight_data;
    logic                  busy;
    logic                  valid;
    logic [MW-1:0]         data_out;

    int                    wm [N][N];
    int                    xm [N][N];
    logic [LANES*BW-1:0]   rom [G*N];
    logic [MW-1:0]         exp_q [$];
    int                    cyc_q [$];
    int                    cyc = 0;
    int                    checks = 0;
    int                    fails = 0;
    logic                  abort = 1'b0;

    mix_layer_tm #(
        .N          (N),
        .BIT_LENGTH (BW),
        .FRAC       (FRAC),
        .LANES      (LANES),
        .ACC_W      (2*BW + 2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .transpose   (transpose),
        .data_in     (data_in),
        .weight_addr (weight_addr),
        .weight_en   (weight_en),
        .weight_data (weight_data),
        .busy        (busy),
        .valid       (valid),
        .data_out    (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (weight_en) weight_data <= rom[weight_addr];

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Y = W * X', each entry floor-shifted by FRAC and clamped to 16 bits
    function automatic logic [MW-1:0] model(input logic tr);
        logic [MW-1:0] y;
        longint s;
        y = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int kk = 0; kk < N; kk++) begin
                    s += longint'(wm[i][kk]) * longint'(tr ? xm[j][kk] : xm[kk][j]);
                end
                s = s >>> FRAC;
                if (s > 32767) s = 32767;
                else if (s < -32768) s = -32768;
                y[(N*i+j)*BW +: BW] = 16'(s);
            end
        end
        return y;
    endfunction

    function automatic int exp_addr(input int n);
        return (n / (N*N)) * N + (n % N);
    endfunction

    function automatic logic [MW-1:0] pack_x();
        logic [MW-1:0] v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                v[(N*r+c)*BW +: BW] = 16'(xm[r][c]);
        return v;
    endfunction

    task automatic load_rom();
        for (int gg = 0; gg < G; gg++)
            for (int kk = 0; kk < N; kk++)
                for (int l = 0; l < LANES; l++)
                    rom[gg*N+kk][l*BW +: BW] = 16'(wm[gg*LANES+l][kk]);
    endtask

    // mode 0: diagonal v, 1: all v, 2: random small values
    task automatic fill_w(input int mode, input logic [15:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (mode)
                    0:       wm[r][c] = (r == c) ? s16(v) : 0;
                    1:       wm[r][c] = s16(v);
                    default: wm[r][c] = int'($urandom_range(1023, 0)) - 512;
                endcase
    endtask

    // mode 0: ramp 0x100*(4r+c), 1: all v, 2: random small values
    task automatic fill_x(input int mode, input logic [15:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                case (mode)
                    0:       xm[r][c] = 256 * (4*r + c);
                    1:       xm[r][c] = s16(v);
                    default: xm[r][c] = int'($urandom_range(2047, 0)) - 1024;
                endcase
    endtask

    task automatic scramble();
        for (int i = 0; i < int'(MW/32); i++) data_in[i*32 +: 32] = $urandom();
        transpose = 1'($urandom());
    endtask

    task automatic launch(input logic tr, output int acc_edge);
        @(negedge clk);
        run       = 1'b1;
        transpose = tr;
        data_in   = pack_x();
        acc_edge  = cyc + 1;
        exp_q.push_back(model(tr));
        cyc_q.push_back(acc_edge + int'(T) + 2);
        abort     = 1'b0;
        @(negedge clk);
        run = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("completion_pending", MW'(exp_q.size()), '0);
        exp_q.delete();
        cyc_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: scoreboard pop on valid, weight address sequence and issue count
    initial begin
        int            iss_n;
        logic          prev_en;
        logic [MW-1:0] y;
        int            e;
        iss_n   = 0;
        prev_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_valid: valid high at cycle %0d with no result pending", cyc);
                end else begin
                    y = exp_q.pop_front();
                    e = cyc_q.pop_front();
                    chk("data_out", data_out, y);
                    chk("valid_latency", MW'(cyc), MW'(e));
                    chk("busy_at_valid", MW'(busy), MW'(1));
                end
            end
            if (weight_en) begin
                chk("weight_addr", MW'(weight_addr), MW'(exp_addr(iss_n)));
                iss_n++;
            end else begin
                if (prev_en && !abort) chk("issue_count", MW'(iss_n), MW'(T));
                iss_n = 0;
            end
            prev_en = weight_en;
        end
    end

    initial begin
        int acc_edge;
        int guard;
        rst       = 1'b1;
        run       = 1'b0;
        transpose = 1'b0;
        data_in   = '0;
        #1;
        chk("rst_busy", MW'(busy), '0);
        chk("rst_valid", MW'(valid), '0);
        chk("rst_weight_en", MW'(weight_en), '0);
        chk("rst_weight_addr", MW'(weight_addr), '0);
        chk("rst_data_out", data_out, '0);
        @(negedge clk);
        rst = 1'b0;

        // Identity weights: plain and transposed pass-through
        fill_w(0, 16'h0100); fill_x(0, 16'h0); load_rom();
        launch(1'b0, acc_edge); wait_done(60);
        launch(1'b1, acc_edge); wait_done(60);

        // Saturation high and low
        fill_w(1, 16'h7F00); fill_x(1, 16'h0100); load_rom();
        launch(1'b0, acc_edge); wait_done(60);
        fill_w(1, 16'h8100); load_rom();
        launch(1'b0, acc_edge); wait_done(60);

        // Floor behaviour of the fractional shift
        fill_w(0, 16'h0080); fill_x(1, 16'h0001); load_rom();
        launch(1'b0, acc_edge); wait_done(60);
        fill_x(1, 16'hFFFF);
        launch(1'b0, acc_edge); wait_done(60);

        // Stray run pulses while busy must not disturb the computation
        fill_w(0, 16'h0100); fill_x(2, 16'h0); load_rom();
        launch(1'b0, acc_edge);
        repeat (3) @(negedge clk);
        run = 1'b1; scramble();
        @(negedge clk); run = 1'b0;
        repeat (14) @(negedge clk);
        run = 1'b1; scramble();
        @(negedge clk); run = 1'b0;
        wait_done(60);

        // run held across DONE: accepted only on the following IDLE edge
        fill_w(2, 16'h0); fill_x(2, 16'h0); load_rom();
        launch(1'b0, acc_edge);
        guard = 0;
        while (cyc < acc_edge + int'(T) + 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        fill_x(2, 16'h0);
        run       = 1'b1;
        transpose = 1'b1;
        data_in   = pack_x();
        exp_q.push_back(model(1'b1));
        cyc_q.push_back(cyc + 2 + int'(T) + 2);
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        scramble();
        wait_done(60);

        // Reset mid-run aborts immediately, then a fresh run completes
        fill_w(2, 16'h0); fill_x(2, 16'h0); load_rom();
        launch(1'b0, acc_edge);
        repeat (14) @(negedge clk);
        abort = 1'b1;
        rst   = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        #1;
        chk("abort_busy", MW'(busy), '0);
        chk("abort_valid", MW'(valid), '0);
        chk("abort_weight_en", MW'(weight_en), '0);
        chk("abort_data_out", data_out, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        launch(1'b0, acc_edge); wait_done(60);

        // Randomized runs against the reference model
        for (int i = 0; i < 6; i++) begin
            fill_w(2, 16'h0); fill_x(2, 16'h0); load_rom();
            launch(1'($urandom()), acc_edge);
            wait_done(60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
